// File: rtl/tcdm_req_initiator.sv
// TCDM initiator: valid/ready word commands in, one req/gnt TCDM port out,
// in-order read data returned through a small response FIFO.
module tcdm_req_initiator #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_add_i,
  input  logic              cmd_wen_i,
  input  logic [3:0]        cmd_be_i,
  input  logic [31:0]       cmd_data_i,
  output logic              tcdm_req_o,
  input  logic              tcdm_gnt_i,
  output logic [ADDR_W-1:0] tcdm_add_o,
  output logic              tcdm_wen_o,
  output logic [3:0]        tcdm_be_o,
  output logic [31:0]       tcdm_data_o,
  input  logic              tcdm_r_valid_i,
  input  logic [31:0]       tcdm_r_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int unsigned OW  = $clog2(MAX_OUTST + 1);
  localparam int unsigned OPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned FW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned FPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] add_q;
  logic              wen_q;
  logic [3:0]        be_q;
  logic [31:0]       data_q;

  logic [OW-1:0]        outst_q;
  logic [OW-1:0]        rd_outst_q;
  logic [MAX_OUTST-1:0] wq_q;
  logic [OPW-1:0]       wq_wp_q;
  logic [OPW-1:0]       wq_rp_q;

  logic [31:0]    fifo_q [RSP_DEPTH];
  logic [FPW-1:0] f_wp_q;
  logic [FPW-1:0] f_rp_q;
  logic [FW-1:0]  f_cnt_q;

  logic        err_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  logic        gnt_now;
  logic        gnt_rd;
  logic        rsp_ok;
  logic        push;
  logic        pop;
  logic        accept;
  logic        credit_ok;
  logic [31:0] o_sum;
  logic [31:0] r_sum;

  function automatic logic [OPW-1:0] wq_inc(input logic [OPW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + OPW'(1);
  endfunction

  function automatic logic [FPW-1:0] f_inc(input logic [FPW-1:0] p);
    return (32'(p) == RSP_DEPTH - 1) ? '0 : p + FPW'(1);
  endfunction

  assign gnt_now = (state_q == REQ) & tcdm_gnt_i;
  assign gnt_rd  = gnt_now & wen_q;
  assign rsp_ok  = tcdm_r_valid_i & (outst_q != '0);
  assign push    = rsp_ok & wq_q[wq_rp_q];
  assign pop     = (f_cnt_q != '0) & rsp_ready_i;

  // A read granted this cycle already owns a FIFO slot before its data lands
  assign o_sum = 32'(outst_q) + 32'(gnt_now);
  assign r_sum = 32'(rd_outst_q) + 32'(f_cnt_q) + 32'(gnt_rd);
  assign credit_ok = (o_sum < MAX_OUTST) & (r_sum < RSP_DEPTH);

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = credit_ok;
        if (cmd_valid_i & credit_ok) state_d = REQ;
      end
      REQ: begin
        cmd_ready_o = tcdm_gnt_i & credit_ok;
        if (tcdm_gnt_i & ~(cmd_valid_i & credit_ok)) state_d = IDLE;
      end
    endcase
  end

  assign accept = cmd_valid_i & cmd_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      add_q   <= '0;
      wen_q   <= 1'b0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        add_q  <= {cmd_add_i[ADDR_W-1:2], 2'b00};
        wen_q  <= cmd_wen_i;
        be_q   <= cmd_be_i;
        data_q <= cmd_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q    <= '0;
      rd_outst_q <= '0;
      wq_q       <= '0;
      wq_wp_q    <= '0;
      wq_rp_q    <= '0;
    end else begin
      if (gnt_now & ~rsp_ok) outst_q <= outst_q + OW'(1);
      else if (~gnt_now & rsp_ok) outst_q <= outst_q - OW'(1);
      if (gnt_rd & ~push) rd_outst_q <= rd_outst_q + OW'(1);
      else if (~gnt_rd & push) rd_outst_q <= rd_outst_q - OW'(1);
      if (gnt_now) begin
        wq_q[wq_wp_q] <= wen_q;
        wq_wp_q       <= wq_inc(wq_wp_q);
      end
      if (rsp_ok) wq_rp_q <= wq_inc(wq_rp_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[f_wp_q] <= tcdm_r_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_wp_q  <= '0;
      f_rp_q  <= '0;
      f_cnt_q <= '0;
    end else begin
      if (push) f_wp_q <= f_inc(f_wp_q);
      if (pop)  f_rp_q <= f_inc(f_rp_q);
      if (push & ~pop) f_cnt_q <= f_cnt_q + FW'(1);
      else if (~push & pop) f_cnt_q <= f_cnt_q - FW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if ((accept & (cmd_add_i[1:0] != 2'b00)) |
          (tcdm_r_valid_i & (outst_q == '0)))
        err_q <= 1'b1;
      if (gnt_rd) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (gnt_now & ~wen_q) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign tcdm_req_o  = (state_q == REQ);
  assign tcdm_add_o  = add_q;
  assign tcdm_wen_o  = wen_q;
  assign tcdm_be_o   = be_q;
  assign tcdm_data_o = data_q;
  assign rsp_valid_o = (f_cnt_q != '0);
  assign rsp_data_o  = rsp_valid_o ? fifo_q[f_rp_q] : '0;
  assign busy_o      = (state_q == REQ) | (outst_q != '0);
  assign err_o       = err_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule
